// File: rtl/filter_gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : filter_gpu_pkg
// Purpose  : Shared widths and types for the Filter-GPU M-stage data memory.
// Revision : 1.0
// ============================================================================
package filter_gpu_pkg;

    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 18;
    localparam int LANES     = 3;
    localparam int VDM_DEPTH = 1024;

    typedef logic [DATA_W-1:0] pixel_t;
    typedef pixel_t [LANES-1:0] lane_vec_t;

    typedef enum logic {
        VDM_CLEAR = 1'b0,
        VDM_READY = 1'b1
    } vdm_state_t;

endpackage
`default_nettype wire

// File: rtl/vdm_clear_seq.sv
`default_nettype none
// ============================================================================
// Module   : vdm_clear_seq
// Purpose  : Post-reset sweep that zeroes every word, then raises mem_ready.
// Revision : 1.0
// ============================================================================
module vdm_clear_seq
    import filter_gpu_pkg::*;
#(
    parameter int DEPTH = VDM_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic             o_clr_we,
    output logic [IDX_W-1:0] o_clr_addr,
    output logic             o_ready,
    output logic             o_mem_ready
);

    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(DEPTH - 1);

    vdm_state_t       r_state_q;
    vdm_state_t       w_state_d;
    logic [IDX_W-1:0] r_clr_addr_q;
    logic [IDX_W-1:0] w_clr_addr_d;
    logic             r_mem_ready_q;
    logic             w_mem_ready_d;

    always_comb begin
        w_state_d     = r_state_q;
        w_clr_addr_d  = r_clr_addr_q;
        w_mem_ready_d = r_mem_ready_q;
        if (r_state_q == VDM_CLEAR) begin
            w_clr_addr_d = r_clr_addr_q + IDX_W'(1);
            // The final word is written on the same edge that enters READY.
            if (r_clr_addr_q == C_LAST) begin
                w_state_d     = VDM_READY;
                w_mem_ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_q     <= VDM_CLEAR;
            r_clr_addr_q  <= '0;
            r_mem_ready_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_clr_addr_q  <= w_clr_addr_d;
            r_mem_ready_q <= w_mem_ready_d;
        end
    end

    assign o_clr_we    = (r_state_q == VDM_CLEAR);
    assign o_clr_addr  = r_clr_addr_q;
    assign o_ready     = (r_state_q == VDM_READY);
    assign o_mem_ready = r_mem_ready_q;

endmodule
`default_nettype wire

// File: rtl/vector_data_mem.sv
`default_nettype none
// ============================================================================
// Module   : vector_data_mem
// Purpose  : 3-lane vector load/store memory for the M stage, with host port.
// Revision : 1.0
// ============================================================================
module vector_data_mem
    import filter_gpu_pkg::*;
#(
    parameter int DEPTH = VDM_DEPTH
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] A1M,
    input  logic [ADDR_W-1:0] A2M,
    input  logic [ADDR_W-1:0] A3M,
    input  lane_vec_t         writeDataM,
    input  logic              MemWriteM,
    output lane_vec_t         RDM,
    output logic              mem_ready,
    input  logic              host_valid,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  pixel_t            host_wdata,
    output logic              host_ready,
    output logic              host_rvalid,
    output pixel_t            host_rdata,
    output logic              oob_err
);

    localparam int                IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] C_DEPTH = ADDR_W'(DEPTH);

    pixel_t            r_mem_q [DEPTH];
    logic [ADDR_W-1:0] w_lane_addr [LANES];
    logic [LANES-1:0]  w_lane_ok;
    logic              w_clr_we;
    logic [IDX_W-1:0]  w_clr_addr;
    logic              w_ready;
    logic              w_host_ok;
    logic              w_host_acc;
    logic              w_oob_hit;

    logic              r_host_rvalid_q;
    logic              w_host_rvalid_d;
    pixel_t            r_host_rdata_q;
    pixel_t            w_host_rdata_d;
    logic              r_oob_q;
    logic              w_oob_d;

    vdm_clear_seq #(
        .DEPTH (DEPTH)
    ) u_clear_seq (
        .i_clk       (CLK),
        .i_rst_n     (RST),
        .o_clr_we    (w_clr_we),
        .o_clr_addr  (w_clr_addr),
        .o_ready     (w_ready),
        .o_mem_ready (mem_ready)
    );

    assign w_lane_addr[0] = A1M;
    assign w_lane_addr[1] = A2M;
    assign w_lane_addr[2] = A3M;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign w_lane_ok[i] = (w_lane_addr[i] < C_DEPTH);
        assign RDM[i] = (w_ready && w_lane_ok[i]) ? r_mem_q[w_lane_addr[i][IDX_W-1:0]] : '0;
    end

    // Pipeline stores always win the array; the host only gets idle cycles.
    assign host_ready = w_ready && !MemWriteM;
    assign w_host_acc = host_valid && host_ready;
    assign w_host_ok  = (host_addr < C_DEPTH);
    assign w_oob_hit  = ((MemWriteM || w_ready) && !(&w_lane_ok)) || (w_host_acc && !w_host_ok);

    // Later assignments override earlier ones, so lane 2 beats lane 0 on a shared address.
    always_ff @(posedge CLK) begin
        if (w_clr_we) begin
            r_mem_q[w_clr_addr] <= '0;
        end else if (MemWriteM) begin
            if (w_lane_ok[0]) r_mem_q[A1M[IDX_W-1:0]] <= writeDataM[0];
            if (w_lane_ok[1]) r_mem_q[A2M[IDX_W-1:0]] <= writeDataM[1];
            if (w_lane_ok[2]) r_mem_q[A3M[IDX_W-1:0]] <= writeDataM[2];
        end else if (w_host_acc && host_we && w_host_ok) begin
            r_mem_q[host_addr[IDX_W-1:0]] <= host_wdata;
        end
    end

    always_comb begin
        w_host_rvalid_d = w_host_acc && !host_we;
        w_host_rdata_d  = r_host_rdata_q;
        w_oob_d         = r_oob_q || w_oob_hit;
        if (w_host_acc && !host_we) begin
            w_host_rdata_d = w_host_ok ? r_mem_q[host_addr[IDX_W-1:0]] : '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_host_rvalid_q <= 1'b0;
            r_host_rdata_q  <= '0;
            r_oob_q         <= 1'b0;
        end else begin
            r_host_rvalid_q <= w_host_rvalid_d;
            r_host_rdata_q  <= w_host_rdata_d;
            r_oob_q         <= w_oob_d;
        end
    end

    assign host_rvalid = r_host_rvalid_q;
    assign host_rdata  = r_host_rdata_q;
    assign oob_err     = r_oob_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_data_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_data_mem
// Purpose  : Scoreboard bench for vector_data_mem with directed vectors.
// Revision : 1.0
// ============================================================================
module tb_vector_data_mem;
    import filter_gpu_pkg::*;

    logic              CLK = 1'b0;
    logic              RST;
    logic [ADDR_W-1:0] A1M, A2M, A3M;
    lane_vec_t         writeDataM;
    logic              MemWriteM;
    lane_vec_t         RDM;
    logic              mem_ready;
    logic              host_valid, host_we;
    logic [ADDR_W-1:0] host_addr;
    pixel_t            host_wdata;
    logic              host_ready, host_rvalid;
    pixel_t            host_rdata;
    logic              oob_err;

    int        n_checks = 0;
    int        n_errors = 0;
    logic      load_chk = 1'b0;
    lane_vec_t rdm_q [$];
    pixel_t    host_q [$];

    vector_data_mem dut (
        .CLK        (CLK),
        .RST        (RST),
        .A1M        (A1M),
        .A2M        (A2M),
        .A3M        (A3M),
        .writeDataM (writeDataM),
        .MemWriteM  (MemWriteM),
        .RDM        (RDM),
        .mem_ready  (mem_ready),
        .host_valid (host_valid),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ready (host_ready),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .oob_err    (oob_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the queued expectations.
    always @(negedge CLK) begin
        if (load_chk) begin
            if (rdm_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rdm_queue: got empty queue expected an entry at %0t", $time);
            end else begin
                lane_vec_t e;
                e = rdm_q.pop_front();
                for (int i = 0; i < LANES; i++)
                    check($sformatf("RDM[%0d]", i), 32'(RDM[i]), 32'(e[i]));
            end
        end
        if (host_rvalid) begin
            if (host_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL host_rvalid: got unexpected pulse expected none at %0t", $time);
            end else begin
                check("host_rdata", 32'(host_rdata), 32'(host_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
        load_chk = 1'b0;
    endtask

    task automatic load(input logic [ADDR_W-1:0] a1, a2, a3, input pixel_t e1, e2, e3);
        lane_vec_t e;
        A1M = a1; A2M = a2; A3M = a3;
        e[0] = e1; e[1] = e2; e[2] = e3;
        rdm_q.push_back(e);
        load_chk = 1'b1;
    endtask

    task automatic store(input logic [ADDR_W-1:0] a1, a2, a3, input pixel_t d1, d2, d3);
        A1M = a1; A2M = a2; A3M = a3;
        writeDataM[0] = d1; writeDataM[1] = d2; writeDataM[2] = d3;
        MemWriteM = 1'b1;
    endtask

    // Counts edges after reset release until mem_ready rises; checks clear-time behaviour.
    task automatic wait_clear(input string nm);
        int   cycles;
        logic hr_low;
        logic rdm_zero;
        cycles   = 0;
        hr_low   = 1'b1;
        rdm_zero = 1'b1;
        while (!mem_ready && cycles < 2000) begin
            A1M = ADDR_W'(cycles % 1024);
            A2M = ADDR_W'((cycles * 7) % 1024);
            A3M = 19'd10;
            @(posedge CLK);
            #1;
            cycles++;
            if (!mem_ready) begin
                if (host_ready) hr_low = 1'b0;
                if (RDM != '0) rdm_zero = 1'b0;
            end
        end
        check({nm, "_clear_cycles"}, 32'(cycles), 32'd1024);
        check({nm, "_host_ready_low"}, 32'(hr_low), 32'd1);
        check({nm, "_rdm_zero"}, 32'(rdm_zero), 32'd1);
    endtask

    initial begin
        RST = 1'b0;
        A1M = '0; A2M = '0; A3M = '0;
        writeDataM = '0;
        MemWriteM  = 1'b0;
        host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_host_ready", 32'(host_ready), 32'd0);
        check("rst_host_rvalid", 32'(host_rvalid), 32'd0);
        check("rst_host_rdata", 32'(host_rdata), 32'd0);
        check("rst_oob_err", 32'(oob_err), 32'd0);

        // Host read held during the clear must not be accepted.
        host_valid = 1'b1; host_we = 1'b0; host_addr = 19'd100;
        RST = 1'b1;
        wait_clear("first");
        host_valid = 1'b0;
        load(19'd0, 19'd511, 19'd1023, 18'h0, 18'h0, 18'h0);

        // Lane stores; same-cycle loads see old data.
        step();
        store(19'd10, 19'd11, 19'd12, 18'h1, 18'h2, 18'h3);
        load(19'd10, 19'd11, 19'd12, 18'h0, 18'h0, 18'h0);
        #1 check("store_host_ready", 32'(host_ready), 32'd0);
        step();
        MemWriteM = 1'b0;
        load(19'd12, 19'd10, 19'd11, 18'h3, 18'h1, 18'h2);

        // All lanes hit word 5: lane 2 wins.
        step();
        store(19'd5, 19'd5, 19'd5, 18'hAAA, 18'hBBB, 18'hCCC);
        step();
        MemWriteM = 1'b0;
        load(19'd5, 19'd5, 19'd5, 18'hCCC, 18'hCCC, 18'hCCC);

        // Host write held off by two pipeline stores.
        step();
        store(19'd20, 19'd21, 19'd22, 18'h7, 18'h8, 18'h9);
        host_valid = 1'b1; host_we = 1'b1; host_addr = 19'd100; host_wdata = 18'h3FFFF;
        #1 check("hostw_blocked", 32'(host_ready), 32'd0);
        step();
        store(19'd23, 19'd24, 19'd25, 18'hA, 18'hB, 18'hC);
        step();
        MemWriteM = 1'b0;
        load(19'd100, 19'd20, 19'd25, 18'h0, 18'h7, 18'hC);
        #1 check("hostw_accept", 32'(host_ready), 32'd1);
        step();
        host_valid = 1'b0;
        load(19'd100, 19'd21, 19'd24, 18'h3FFFF, 18'h8, 18'hB);

        // Back-to-back host reads.
        step();
        host_valid = 1'b1; host_we = 1'b0; host_addr = 19'd100;
        host_q.push_back(18'h3FFFF);
        step();
        check("hostr_latency", 32'(host_rvalid), 32'd1);
        host_addr = 19'd10;
        host_q.push_back(18'h1);
        step();
        host_valid = 1'b0;
        step();
        check("hostr_pulse_end", 32'(host_rvalid), 32'd0);

        // Out-of-range lane store is dropped and flags oob_err.
        check("oob_pre", 32'(oob_err), 32'd0);
        store(19'd30, 19'd2000, 19'd31, 18'h11, 18'h22, 18'h33);
        step();
        MemWriteM = 1'b0;
        check("oob_set", 32'(oob_err), 32'd1);
        load(19'd30, 19'd2000, 19'd31, 18'h11, 18'h0, 18'h33);
        step();
        load(19'd976, 19'd31, 19'd30, 18'h0, 18'h33, 18'h11);
        step();
        A1M = 19'd1; A2M = 19'd2; A3M = 19'd3;
        host_valid = 1'b1; host_we = 1'b0; host_addr = 19'd5000;
        host_q.push_back(18'h0);
        step();
        host_valid = 1'b0;
        repeat (3) step();
        check("oob_sticky", 32'(oob_err), 32'd1);

        // Reset right after a host read is accepted cancels the pending pulse.
        host_valid = 1'b1; host_we = 1'b0; host_addr = 19'd100;
        @(posedge CLK);
        #1;
        host_valid = 1'b0;
        RST = 1'b0;
        #1;
        check("rst2_host_rvalid", 32'(host_rvalid), 32'd0);
        check("rst2_host_rdata", 32'(host_rdata), 32'd0);
        check("rst2_mem_ready", 32'(mem_ready), 32'd0);
        check("rst2_oob_err", 32'(oob_err), 32'd0);
        check("rst2_host_ready", 32'(host_ready), 32'd0);
        step();
        RST = 1'b1;
        repeat (300) step();
        check("mid_clear_ready", 32'(mem_ready), 32'd0);
        RST = 1'b0;
        #1 check("rst3_mem_ready", 32'(mem_ready), 32'd0);
        step();
        RST = 1'b1;
        wait_clear("restart");
        load(19'd10, 19'd5, 19'd100, 18'h0, 18'h0, 18'h0);
        step();

        repeat (3) step();
        check("rdm_queue_drained", 32'(rdm_q.size()), 32'd0);
        check("host_queue_drained", 32'(host_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
